instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; rst_n  in  1  reset, asynchronous assert, active-low.
REQ-002 SHALL have ports: in_valid  in  1; in_ready  out  1; fmt  in  3  risc_pkg::fmt_e (R/I/S/B/U/J); opcode  in  7; funct3  in  3; funct7  in  7; rd  in  5; rs1  in  5; rs2  in  5; imm  in  32  signed byte offset/value.
REQ-003 SHALL have ports: base_load  in  1  load program counter; base_addr  in  32  new start address.
REQ-004 SHALL have ports: out_valid  out  1; out_ready  in  1; out_instr  out  32  encoded word; out_addr  out  32  word address for instruction memory; out_err  out  1  immediate/format not representable.
REQ-005 SHALL have ports: err_seen  out  1  sticky error; count  out  16  instructions emitted, saturating.

Function
REQ-006 SHALL implement a single registered output stage: in_ready = (!out_valid || out_ready) && !base_load.
REQ-007 SHALL accept a request when in_valid && in_ready; out_instr, out_addr and out_err SHALL be valid the next cycle, giving 1-cycle latency and full throughput.
REQ-008 SHALL hold out_instr, out_addr and out_err stable while out_valid && !out_ready.
REQ-009 SHALL clear out_valid on out_ready when there is no new accept in the same cycle; a simultaneous drain and accept SHALL keep out_valid=1 with the new data.
REQ-010 SHALL encode fields as follows:
- R: funct7|rs2|rs1|funct3|rd|opcode
- I: imm[11:0]|rs1|funct3|rd|opcode
- S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode
- B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode
- U: imm[31:12]|rd|opcode
- J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode
REQ-011 SHALL set out_err for:
- I/S: imm not a 12-bit sign-extension
- B: imm not 13-bit signed, or imm[0]=1
- J: imm not 21-bit signed, or imm[0]=1
- U: imm[11:0]!=0
- fmt outside R..J, or opcode[1:0]!=2'b11
REQ-012 SHALL still emit errored words, encoded with truncated bits per REQ-010; an errored word advances the PC and increments count.
REQ-013 SHALL maintain pc: out_addr = pc at accept; pc += 4 per accept, wrapping at 2^32.
REQ-014 SHALL load pc = {base_addr[31:2],2'b00} on base_load, and SHALL clear err_seen and count on base_load; base_load takes priority, and no accept occurs that cycle (REQ-006).
REQ-015 SHALL leave a word already held in the output register untouched by base_load.
REQ-016 SHALL set err_seen when an accepted request errors; it clears only on reset or base_load.
REQ-017 SHALL increment count per accept and saturate at 16'hFFFF.

Reset
REQ-018 SHALL, on rst_n low and asynchronously, set out_valid=0, out_instr=0, out_addr=0, out_err=0, pc=0, count=0, err_seen=0.
REQ-019 SHALL discard any pending output word when reset occurs mid-stall; in_ready SHALL be 1 in the first cycle after release.

Structure
REQ-020 SHALL take fmt_e (FMT_R=0..FMT_J=5) and the opcode constants from risc_pkg, shared with decode.
REQ-021 SHALL place the pure combinational field packer and range check in one sub-module, instr_pack; pc, count and the handshake live in instr_encoder.

Verification
REQ-022 SHALL cover: I fmt, opcode 0010011, rd=1, rs1=0, f3=0, imm=5, after reset -> next cycle out_instr=0x00500093, out_addr=0, out_err=0.
REQ-023 SHALL cover: R add rd=3, rs1=1, rs2=2 -> 0x002081B3; B beq rs1=1, rs2=2, imm=8 -> 0x00208463; U lui rd=5, imm=0x12345000 -> 0x123452B7; out_addr sequence 0, 4, 8.
REQ-024 SHALL cover: I imm=2048 -> out_err=1, err_seen=1; B imm=3 -> out_err=1; count still increments on both.
REQ-025 SHALL cover: out_ready low for 3 cycles with in_valid high -> in_ready=0, output stable; then out_ready high -> one word per cycle, none lost or duplicated.
REQ-026 SHALL cover: base_load with base_addr=0x00001003 and in_valid high -> no accept that cycle; next accepted word out_addr=0x00001000, count=1, err_seen=0.
REQ-027 SHALL cover: rst_n asserted mid-stall -> out_valid=0 immediately, pc=0 after release.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared RISC-V encoding definitions used by the encoder and the decoder.
// Holds the instruction format enumeration, major opcodes and immediate range helper.
package risc_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // True when v is the sign extension of its low w bits: everything from bit w-1 up
    // must be all zeros or all ones.
    function automatic logic sext_ok(input logic [31:0] v, input int unsigned w);
        logic [31:0] upper;
        upper = 32'($signed(v) >>> (w - 1));
        return (upper == '0) || (upper == '1);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Purely combinational RISC-V field packer with immediate/format range checking.
// Unknown formats produce an all-zero word flagged as an error.
module instr_pack import risc_pkg::*; (
    input  fmt_e        fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        err
);

    always_comb begin
        instr = '0;
        err   = 1'b0;
        case (fmt)
            FMT_R: begin
                instr = {funct7, rs2, rs1, funct3, rd, opcode};
            end
            FMT_I: begin
                instr = {imm[11:0], rs1, funct3, rd, opcode};
                err   = !sext_ok(imm, 12);
            end
            FMT_S: begin
                instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                err   = !sext_ok(imm, 12);
            end
            FMT_B: begin
                instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                err   = !sext_ok(imm, 13) || imm[0];
            end
            FMT_U: begin
                instr = {imm[31:12], rd, opcode};
                err   = |imm[11:0];
            end
            FMT_J: begin
                instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                err   = !sext_ok(imm, 21) || imm[0];
            end
            default: begin
                err = 1'b1;
            end
        endcase
        // Every 32-bit RISC-V opcode has its two low bits set.
        if (opcode[1:0] != 2'b11) begin
            err = 1'b1;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: one registered output stage carrying the packed word and its
// address, plus the program counter, emitted-word counter and sticky error flag.
module instr_encoder import risc_pkg::*; (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  fmt_e        fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    input  logic        base_load,
    input  logic [31:0] base_addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        out_err,
    output logic        err_seen,
    output logic [15:0] count
);

    logic [31:0] pc;
    logic [31:0] pack_instr;
    logic        pack_err;
    logic        accept;

    // base_load blocks acceptance so the PC update never races a new word.
    assign in_ready = (!out_valid || out_ready) && !base_load;
    assign accept   = in_valid && in_ready;

    instr_pack u_pack (
        .fmt    (fmt),
        .opcode (opcode),
        .funct3 (funct3),
        .funct7 (funct7),
        .rd     (rd),
        .rs1    (rs1),
        .rs2    (rs2),
        .imm    (imm),
        .instr  (pack_instr),
        .err    (pack_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_addr  <= '0;
            out_err   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_instr <= pack_instr;
            out_addr  <= pc;
            out_err   <= pack_err;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= '0;
            count    <= '0;
            err_seen <= 1'b0;
        end else if (base_load) begin
            pc       <= {base_addr[31:2], 2'b00};
            count    <= '0;
            err_seen <= 1'b0;
        end else if (accept) begin
            pc <= pc + 32'd4;
            if (count != 16'hFFFF) begin
                count <= count + 16'd1;
            end
            if (pack_err) begin
                err_seen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized traffic
// compared against a behavioural model of the encoder.
module tb_instr_encoder;
    import risc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    fmt_e        fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        base_load;
    logic [31:0] base_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_err;
    logic        err_seen;
    logic [15:0] count;

    int n_checks = 0;
    int n_fails  = 0;

    // Behavioural model state
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_addr;
    logic        m_err;
    logic [31:0] m_pc;
    int          m_count;
    logic        m_err_seen;
    logic        exp_ready;
    logic        obs_ready;

    instr_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fmt       (fmt),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7    (funct7),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .base_load (base_load),
        .base_addr (base_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .out_err   (out_err),
        .err_seen  (err_seen),
        .count     (count)
    );

    always #5 clk = ~clk;

    // Returns {err, word}; range checks are done on the signed integer value.
    function automatic logic [32:0] ref_encode(input int f, input logic [6:0] op,
                                               input logic [2:0] f3, input logic [6:0] f7,
                                               input logic [4:0] d, input logic [4:0] s1,
                                               input logic [4:0] s2, input logic [31:0] im);
        logic [31:0] w;
        logic        e;
        int          si;
        si = int'($signed(im));
        w  = '0;
        e  = 1'b0;
        case (f)
            0: w = {f7, s2, s1, f3, d, op};
            1: begin
                w = {im[11:0], s1, f3, d, op};
                e = (si < -2048) || (si > 2047);
            end
            2: begin
                w = {im[11:5], s2, s1, f3, im[4:0], op};
                e = (si < -2048) || (si > 2047);
            end
            3: begin
                w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
                e = (si < -4096) || (si > 4095) || (si % 2 != 0);
            end
            4: begin
                w = {im[31:12], d, op};
                e = (im % 4096) != 0;
            end
            5: begin
                w = {im[20], im[10:1], im[11], im[19:12], d, op};
                e = (si < -1048576) || (si > 1048575) || (si % 2 != 0);
            end
            default: e = 1'b1;
        endcase
        if (op % 4 != 3) e = 1'b1;
        return {e, w};
    endfunction

    task automatic model_reset();
        m_valid    = 1'b0;
        m_instr    = '0;
        m_addr     = '0;
        m_err      = 1'b0;
        m_pc       = '0;
        m_count    = 0;
        m_err_seen = 1'b0;
    endtask

    task automatic set_req(input logic v, input int f, input logic [6:0] op,
                           input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] d,
                           input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im);
        logic [2:0] f_bits;
        f_bits   = f[2:0];
        in_valid = v;
        fmt      = fmt_e'(f_bits);
        opcode   = op;
        funct3   = f3;
        funct7   = f7;
        rd       = d;
        rs1      = s1;
        rs2      = s2;
        imm      = im;
    endtask

    // Advances one clock with the current inputs, updating the model; ends 1 ns after the edge.
    task automatic cycle();
        logic [32:0] enc;
        logic        acc;
        #1;
        obs_ready = in_ready;
        exp_ready = (!m_valid || out_ready) && !base_load;
        acc = in_valid && exp_ready;
        enc = ref_encode(int'(fmt), opcode, funct3, funct7, rd, rs1, rs2, imm);
        if (base_load) begin
            m_pc       = {base_addr[31:2], 2'b00};
            m_count    = 0;
            m_err_seen = 1'b0;
        end
        if (acc) begin
            m_valid = 1'b1;
            m_instr = enc[31:0];
            m_err   = enc[32];
            m_addr  = m_pc;
            m_pc    = m_pc + 32'd4;
            if (m_count < 65535) m_count = m_count + 1;
            if (enc[32]) m_err_seen = 1'b1;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        base_load = 1'b0;
        base_addr = '0;
        out_ready = 1'b1;
        set_req(1'b0, 0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        n_checks++;
        if ({out_instr, out_addr, out_err} !== 65'd0) begin
            n_fails++;
            $display("FAIL reset_outputs: instr %h addr %h err %b expected all zero",
                     out_instr, out_addr, out_err);
        end
        n_checks++;
        if (count !== 16'd0 || err_seen !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_count: count %0d err_seen %b expected 0/0", count, err_seen);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_first_addi();
        set_req(1'b1, 1, OPC_OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        cycle();
        n_checks++;
        if (out_valid !== 1'b1 || out_instr !== 32'h00500093 || out_addr !== 32'd0
            || out_err !== 1'b0) begin
            n_fails++;
            $display("FAIL first_addi: valid %b instr %h addr %h err %b expected 1 00500093 0 0",
                     out_valid, out_instr, out_addr, out_err);
        end
        set_req(1'b0, 0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        cycle();
    endtask

    task automatic test_encodings();
        logic [31:0] exp_w [3];
        exp_w[0] = 32'h002081B3;
        exp_w[1] = 32'h00208463;
        exp_w[2] = 32'h123452B7;
        base_load = 1'b1;
        base_addr = 32'd0;
        cycle();
        base_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       set_req(1'b1, 0, OPC_OP, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
                1:       set_req(1'b1, 3, OPC_BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
                default: set_req(1'b1, 4, OPC_LUI, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000);
            endcase
            cycle();
            n_checks++;
            if (out_instr !== exp_w[i] || out_addr !== 32'(i * 4) || out_err !== 1'b0) begin
                n_fails++;
                $display("FAIL encode_%0d: instr %h addr %h err %b expected %h %h 0",
                         i, out_instr, out_addr, out_err, exp_w[i], 32'(i * 4));
            end
        end
        set_req(1'b0, 0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        cycle();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL drain_idle: out_valid %b expected 0", out_valid);
        end
    endtask

    task automatic test_errors();
        logic [15:0] c0;
        c0 = count;
        set_req(1'b1, 1, OPC_OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        cycle();
        n_checks++;
        if (out_err !== 1'b1 || err_seen !== 1'b1 || count !== c0 + 16'd1) begin
            n_fails++;
            $display("FAIL err_imm_2048: err %b seen %b count %0d expected 1 1 %0d",
                     out_err, err_seen, count, c0 + 16'd1);
        end
        set_req(1'b1, 3, OPC_BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
        cycle();
        n_checks++;
        if (out_err !== 1'b1 || count !== c0 + 16'd2) begin
            n_fails++;
            $display("FAIL err_branch_odd: err %b count %0d expected 1 %0d",
                     out_err, count, c0 + 16'd2);
        end
        set_req(1'b1, 6, OPC_OP, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0);
        cycle();
        n_checks++;
        if (out_err !== 1'b1 || out_instr !== 32'd0) begin
            n_fails++;
            $display("FAIL err_bad_fmt: err %b instr %h expected 1 00000000", out_err, out_instr);
        end
        set_req(1'b1, 0, 7'b0110010, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0);
        cycle();
        n_checks++;
        if (out_err !== 1'b1) begin
            n_fails++;
            $display("FAIL err_bad_opcode: err %b expected 1", out_err);
        end
        set_req(1'b0, 0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        cycle();
    endtask

    task automatic test_stall();
        logic [31:0] held_w;
        logic [31:0] held_a;
        logic [32:0] enc;
        out_ready = 1'b0;
        set_req(1'b1, 0, OPC_OP, 3'd0, 7'd0, 5'd10, 5'd1, 5'd2, 32'd0);
        cycle();
        held_w = ref_encode(0, OPC_OP, 3'd0, 7'd0, 5'd10, 5'd1, 5'd2, 32'd0);
        held_a = m_addr;
        set_req(1'b1, 0, OPC_OP, 3'd0, 7'd0, 5'd11, 5'd1, 5'd2, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if (obs_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== held_w
                || out_addr !== held_a) begin
                n_fails++;
                $display("FAIL stall_hold_%0d: ready %b valid %b instr %h addr %h expected 0 1 %h %h",
                         i, obs_ready, out_valid, out_instr, out_addr, held_w, held_a);
            end
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_req(1'b1, 0, OPC_OP, 3'd0, 7'd0, 5'(11 + k), 5'd1, 5'd2, 32'd0);
            cycle();
            enc = ref_encode(0, OPC_OP, 3'd0, 7'd0, 5'(11 + k), 5'd1, 5'd2, 32'd0);
            n_checks++;
            if (out_valid !== 1'b1 || out_instr !== enc[31:0]
                || out_addr !== held_a + 32'(4 * (k + 1))) begin
                n_fails++;
                $display("FAIL stall_release_%0d: valid %b instr %h addr %h expected 1 %h %h",
                         k, out_valid, out_instr, out_addr, enc[31:0], held_a + 32'(4 * (k + 1)));
            end
        end
        set_req(1'b0, 0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        cycle();
    endtask

    task automatic test_base_load();
        logic [31:0] held_w;
        out_ready = 1'b1;
        base_load = 1'b1;
        base_addr = 32'h00001003;
        set_req(1'b1, 1, OPC_OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd7);
        cycle();
        n_checks++;
        if (obs_ready !== 1'b0 || out_valid !== 1'b0 || count !== 16'd0 || err_seen !== 1'b0) begin
            n_fails++;
            $display("FAIL base_load_cycle: ready %b valid %b count %0d seen %b expected 0 0 0 0",
                     obs_ready, out_valid, count, err_seen);
        end
        base_load = 1'b0;
        cycle();
        n_checks++;
        if (out_addr !== 32'h00001000 || count !== 16'd1 || err_seen !== 1'b0
            || out_valid !== 1'b1) begin
            n_fails++;
            $display("FAIL base_load_next: addr %h count %0d seen %b valid %b expected 1000 1 0 1",
                     out_addr, count, err_seen, out_valid);
        end
        // A held word must survive a base_load while stalled.
        out_ready = 1'b0;
        held_w = out_instr;
        base_load = 1'b1;
        base_addr = 32'h00002000;
        cycle();
        n_checks++;
        if (out_valid !== 1'b1 || out_instr !== held_w || out_addr !== 32'h00001000) begin
            n_fails++;
            $display("FAIL base_load_held: valid %b instr %h addr %h expected 1 %h 00001000",
                     out_valid, out_instr, out_addr, held_w);
        end
        base_load = 1'b0;
        out_ready = 1'b1;
        cycle();
        n_checks++;
        if (out_addr !== 32'h00002000) begin
            n_fails++;
            $display("FAIL base_load_new_pc: addr %h expected 00002000", out_addr);
        end
        set_req(1'b0, 0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        cycle();
    endtask

    task automatic test_random();
        logic [6:0]  ops [6];
        logic [31:0] im;
        int          f;
        logic [6:0]  op;
        ops[0] = OPC_OP;     ops[1] = OPC_OP_IMM; ops[2] = OPC_STORE;
        ops[3] = OPC_BRANCH; ops[4] = OPC_LUI;    ops[5] = OPC_JAL;
        for (int n = 0; n < 500; n++) begin
            f = int'($urandom_range(0, 15));
            f = (f < 14) ? f % 6 : 6 + f % 2;
            op = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[f % 6];
            case ($urandom_range(0, 3))
                0:       im = $urandom;
                1:       im = 32'(int'($urandom_range(0, 10000)) - 5000);
                2:       im = 32'((int'($urandom_range(0, 5000)) - 2500) * 2);
                default: im = $urandom & 32'hFFFFF000;
            endcase
            set_req(1'($urandom), f, op, 3'($urandom), 7'($urandom), 5'($urandom),
                    5'($urandom), 5'($urandom), im);
            out_ready = ($urandom_range(0, 3) != 0);
            base_load = ($urandom_range(0, 19) == 0);
            base_addr = $urandom;
            cycle();
            n_checks++;
            if (obs_ready !== exp_ready) begin
                n_fails++;
                $display("FAIL rand_in_ready[%0d]: got %b expected %b", n, obs_ready, exp_ready);
            end
            n_checks++;
            if (out_valid !== m_valid) begin
                n_fails++;
                $display("FAIL rand_out_valid[%0d]: got %b expected %b", n, out_valid, m_valid);
            end
            if (m_valid) begin
                n_checks++;
                if (out_instr !== m_instr || out_addr !== m_addr || out_err !== m_err) begin
                    n_fails++;
                    $display("FAIL rand_word[%0d]: instr %h addr %h err %b expected %h %h %b",
                             n, out_instr, out_addr, out_err, m_instr, m_addr, m_err);
                end
            end
            n_checks++;
            if (count !== 16'(m_count) || err_seen !== m_err_seen) begin
                n_fails++;
                $display("FAIL rand_status[%0d]: count %0d seen %b expected %0d %b",
                         n, count, err_seen, m_count, m_err_seen);
            end
        end
        base_load = 1'b0;
        out_ready = 1'b1;
        set_req(1'b0, 0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        cycle();
    endtask

    task automatic test_reset_mid_stall();
        out_ready = 1'b0;
        set_req(1'b1, 0, OPC_OP, 3'd0, 7'd0, 5'd4, 5'd1, 5'd2, 32'd0);
        cycle();
        cycle();
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || count !== 16'd0 || out_addr !== 32'd0) begin
            n_fails++;
            $display("FAIL reset_mid_stall: valid %b count %0d addr %h expected 0 0 0",
                     out_valid, count, out_addr);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL reset_release_ready: got %b expected 1", in_ready);
        end
        out_ready = 1'b1;
        cycle();
        n_checks++;
        if (out_valid !== 1'b1 || out_addr !== 32'd0 || count !== 16'd1) begin
            n_fails++;
            $display("FAIL reset_pc_zero: valid %b addr %h count %0d expected 1 0 1",
                     out_valid, out_addr, count);
        end
        set_req(1'b0, 0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        cycle();
    endtask

    initial begin
        test_reset();
        test_first_addi();
        test_encodings();
        test_errors();
        test_stall();
        test_base_load();
        test_random();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
